// File: rtl/serial_word_adder.sv
// Word-level wrapper around a bit-serial full adder: it accepts two W-bit operands and adds them LSB-first, one bit per cycle, then returns the sum word and the carry.
// Optional macro SERIAL_WORD_ADDER_SUB_EN adds a `sub` input that selects a - b.
module serial_word_adder #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
`ifdef SERIAL_WORD_ADDER_SUB_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         carry_out
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high. in_ready and out_valid are decoded from state only.
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_sh, b_sh, res_sh, res_next, sum_q;
   logic            c_q, carry_q;
   logic [CW-1:0]   cnt_q;
   logic            a0, b0, s_bit, c_next, last_bit, init_carry;

`ifdef SERIAL_WORD_ADDER_SUB_EN
   logic            sub_q;
   assign b0         = b_sh[0] ^ sub_q;
   assign init_carry = sub;
`else
   assign b0         = b_sh[0];
   assign init_carry = 1'b0;
`endif

   assign a0       = a_sh[0];
   assign s_bit    = a0 ^ b0 ^ c_q;
   assign c_next   = (a0 & b0) | (a0 & c_q) | (b0 & c_q);
   assign last_bit = (cnt_q == LAST);

   always_comb begin
      res_next        = res_sh >> 1;
      res_next[W-1]   = s_bit;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = BUSY;
         BUSY:    if (last_bit) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_WORD_ADDER_SUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  c_q   <= init_carry;
                  cnt_q <= '0;
`ifdef SERIAL_WORD_ADDER_SUB_EN
                  sub_q <= sub;
`endif
               end
            end
            BUSY: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               c_q    <= c_next;
               cnt_q  <= cnt_q + 1'b1;
               // Visible result only changes once the whole word is ready.
               if (last_bit) begin
                  sum_q   <= res_next;
                  carry_q <= c_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_word_adder.sv
// Scoreboard bench for serial_word_adder: directed operand pairs with hand-computed results.
// A negedge monitor pops the expected queue on every output transfer.
module tb_serial_word_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
`ifdef SERIAL_WORD_ADDER_SUB_EN
   logic         sub = 1'b0;
`endif
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         carry_out;

   int total = 0;
   int bad   = 0;
   logic [W:0] exp_q[$];

   logic         held = 1'b0;
   logic [W-1:0] held_sum;
   logic         held_c;

   serial_word_adder #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
`ifdef SERIAL_WORD_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares on each output transfer and checks hold under backpressure.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (held) begin
            chk("hold_sum", 32'(sum), 32'(held_sum));
            chk("hold_carry", 32'(carry_out), 32'(held_c));
         end
         if (out_ready) begin
            held = 1'b0;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_out: got %0h/%0b expected no result", sum, carry_out);
            end else begin
               logic [W:0] e;
               e = exp_q.pop_front();
               chk("result_sum", 32'(sum), 32'(e[W-1:0]));
               chk("result_carry", 32'(carry_out), 32'(e[W]));
            end
         end else begin
            held     = 1'b1;
            held_sum = sum;
            held_c   = carry_out;
         end
      end else begin
         held = 1'b0;
      end
   end

   // Issues one operand pair and checks the handshake timing around it.
   // hold: cycles of out_ready=0 after out_valid; pulse: inject an ignored in_valid during BUSY.
   task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                        input logic [W-1:0] es, input logic ec, input int hold, input bit pulse);
      chk("in_ready_before", 32'(in_ready), 32'd1);
      a = ai;
      b = bi;
`ifdef SERIAL_WORD_ADDER_SUB_EN
      sub = si;
`endif
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      exp_q.push_back({ec, es});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      for (int i = 1; i < W; i++) begin
         if (pulse && i == 3) begin
            a = 8'h11;
            b = 8'h22;
            in_valid = 1'b1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      chk("out_valid_early", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("out_valid_latency", 32'(out_valid), 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after", 32'(in_ready), 32'd1);
      chk("out_valid_after", 32'(out_valid), 32'd0);
      chk("sum_kept", 32'(sum), 32'(es));
      chk("carry_kept", 32'(carry_out), 32'(ec));
      if (si) total = total + 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_carry", 32'(carry_out), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
      do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
      do_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 0, 1'b0);
      do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 5, 1'b0);
      do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 1'b1);
      repeat (W + 2) begin
         @(posedge clk); #1;
         chk("no_capture_idle", 32'(in_ready), 32'd1);
      end

      // Reset three cycles into BUSY discards the partial result.
      a = 8'hAA;
      b = 8'h55;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      chk("midrst_carry", 32'(carry_out), 32'd0);
      do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0, 1'b0);

`ifdef SERIAL_WORD_ADDER_SUB_EN
      do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 0, 1'b0);
      do_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 0, 1'b0);
      do_op(8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
